// File: rtl/gt_reset_seq_pkg.sv
// GT reset sequencer shared types.
// State encodings and default timing constants.
package gt_reset_seq_pkg;

   typedef enum logic [1:0] {
      ST_INACTIVE  = 2'd0,
      ST_WAIT_DONE = 2'd1,
      ST_RUN       = 2'd2,
      ST_FAULT     = 2'd3
   } seq_state_e;

   localparam int DEF_LOCK_TIMEOUT = 322266;
   localparam int DEF_PULSE_LEN    = 16;
   localparam int DEF_MAX_RETRY    = 3;

endpackage

// File: rtl/gt_reset_seq_lock_mon.sv
// Per-channel block-lock monitor: synchroniser, loss-of-lock timer,
// datapath reset pulse and retry bookkeeping.
module gt_reset_seq_lock_mon #(
   parameter int SYNC_STAGES  = 2,
   parameter int LOCK_TIMEOUT = gt_reset_seq_pkg::DEF_LOCK_TIMEOUT,
   parameter int PULSE_LEN    = gt_reset_seq_pkg::DEF_PULSE_LEN,
   parameter int MAX_RETRY    = gt_reset_seq_pkg::DEF_MAX_RETRY,
   parameter int RETRY_W      = $clog2(MAX_RETRY + 1)
) (
   input  logic               gt_txusrclk,
   input  logic               gt_tx_reset,
   input  logic               lock_in,
   input  logic               run,
   input  logic               abort,
   input  logic               clr_retry,
   output logic               lock_sync,
   output logic               dp_req,
   output logic               fault_req,
   output logic [RETRY_W-1:0] retry
);

   localparam int CW = $clog2(LOCK_TIMEOUT + 1);
   localparam int PW = $clog2(PULSE_LEN + 1);
   localparam logic [CW-1:0]      CNT_LAST   = CW'(LOCK_TIMEOUT - 1);
   localparam logic [PW-1:0]      PULSE_INIT = PW'(PULSE_LEN);
   localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [PW-1:0]          pcnt_q, pcnt_d;
   logic [RETRY_W-1:0]     retry_q, retry_d;
   logic                   change, busy, expire, start;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], lock_in};
      // change is seen one stage early so the timer restarts
      // on the same edge the synchronised lock flips
      change    = sync_q[SYNC_STAGES-1] ^ sync_q[SYNC_STAGES-2];
      busy      = (pcnt_q != '0);
      expire    = run && !busy && !change && (cnt_q == CNT_LAST);
      start     = expire && !lock_sync && (retry_q < RETRY_MAX) && !abort;
      fault_req = expire && !lock_sync && (retry_q == RETRY_MAX);

      cnt_d = cnt_q + 1'b1;
      if (!run || abort || change || expire)
         cnt_d = '0;
      else if (busy)
         cnt_d = cnt_q;

      pcnt_d = pcnt_q;
      if (!run || abort)
         pcnt_d = '0;
      else if (start)
         pcnt_d = PULSE_INIT;
      else if (busy)
         pcnt_d = pcnt_q - 1'b1;

      retry_d = retry_q;
      if (clr_retry || (expire && lock_sync))
         retry_d = '0;
      else if (start)
         retry_d = retry_q + 1'b1;
   end

   always_ff @(posedge gt_txusrclk or posedge gt_tx_reset) begin
      if (gt_tx_reset) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         pcnt_q  <= '0;
         retry_q <= '0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         pcnt_q  <= pcnt_d;
         retry_q <= retry_d;
      end
   end

   assign lock_sync = sync_q[SYNC_STAGES-1];
   assign dp_req    = busy;
   assign retry     = retry_q;

endmodule

// File: rtl/gt_reset_seq.sv
// GT TX reset sequencer: brings up the user clock, waits for reset
// done, releases tx_rst and escalates lock-loss recovery.
module gt_reset_seq #(
   parameter int CH_COUNT     = 2,
   parameter int SYNC_STAGES  = 2,
   parameter int RST_STAGES   = 4,
   parameter int LOCK_TIMEOUT = gt_reset_seq_pkg::DEF_LOCK_TIMEOUT,
   parameter int PULSE_LEN    = gt_reset_seq_pkg::DEF_PULSE_LEN,
   parameter int MAX_RETRY    = gt_reset_seq_pkg::DEF_MAX_RETRY,
   localparam int RETRY_W     = $clog2(MAX_RETRY + 1)
) (
   input  logic                        gt_txusrclk,
   input  logic                        gt_tx_reset,
   input  logic                        gt_reset_tx_done,
   input  logic [CH_COUNT-1:0]         rx_block_lock,
   output logic                        userclk_tx_active,
   output logic                        tx_rst,
   output logic [CH_COUNT-1:0]         rx_dp_reset_req,
   output logic                        reset_all_req,
   output logic [1:0]                  state,
   output logic [CH_COUNT-1:0]         lock_status,
   output logic [CH_COUNT*RETRY_W-1:0] retry_count
);

   import gt_reset_seq_pkg::*;

   localparam int RW = $clog2(RST_STAGES + 1);
   localparam int FW = $clog2(PULSE_LEN + 1);
   localparam logic [RW-1:0] RST_LAST = RW'(RST_STAGES - 1);
   localparam logic [FW-1:0] FLT_LAST = FW'(PULSE_LEN - 1);

   seq_state_e             state_q, state_d;
   logic                   active_q, active_d;
   logic                   tx_rst_q, tx_rst_d;
   logic                   rall_q, rall_d;
   logic [RW-1:0]          rcnt_q, rcnt_d;
   logic [FW-1:0]          fcnt_q, fcnt_d;
   logic [SYNC_STAGES-1:0] done_q, done_d;
   logic                   done_s, run, stay_run, leave, clr_retry;
   logic [CH_COUNT-1:0]    fault_vec;

   always_comb begin
      done_d   = {done_q[SYNC_STAGES-2:0], gt_reset_tx_done};
      done_s   = done_q[SYNC_STAGES-1];
      active_d = 1'b1;
      state_d  = state_q;
      unique case (state_q)
         ST_INACTIVE:  if (active_q) state_d = ST_WAIT_DONE;
         ST_WAIT_DONE: if (done_s) state_d = ST_RUN;
         // losing done outranks a lock fault
         ST_RUN: begin
            if (!done_s)
               state_d = ST_WAIT_DONE;
            else if (|fault_vec)
               state_d = ST_FAULT;
         end
         ST_FAULT:     if (fcnt_q == FLT_LAST) state_d = ST_WAIT_DONE;
      endcase

      run       = (state_q == ST_RUN);
      stay_run  = run && (state_d == ST_RUN);
      leave     = run && !stay_run;
      clr_retry = (state_q == ST_FAULT) && (state_d != ST_FAULT);

      rcnt_d = '0;
      if (stay_run)
         rcnt_d = (rcnt_q == RST_LAST) ? rcnt_q : rcnt_q + 1'b1;
      tx_rst_d = !(stay_run && (rcnt_q == RST_LAST));

      fcnt_d = '0;
      if ((state_q == ST_FAULT) && (state_d == ST_FAULT))
         fcnt_d = fcnt_q + 1'b1;
      rall_d = (state_d == ST_FAULT);
   end

   always_ff @(posedge gt_txusrclk or posedge gt_tx_reset) begin
      if (gt_tx_reset) begin
         state_q  <= ST_INACTIVE;
         active_q <= 1'b0;
         tx_rst_q <= 1'b1;
         rall_q   <= 1'b0;
         rcnt_q   <= '0;
         fcnt_q   <= '0;
         done_q   <= '0;
      end else begin
         state_q  <= state_d;
         active_q <= active_d;
         tx_rst_q <= tx_rst_d;
         rall_q   <= rall_d;
         rcnt_q   <= rcnt_d;
         fcnt_q   <= fcnt_d;
         done_q   <= done_d;
      end
   end

   for (genvar n = 0; n < CH_COUNT; n++) begin : g_ch
      gt_reset_seq_lock_mon #(
         .SYNC_STAGES  (SYNC_STAGES),
         .LOCK_TIMEOUT (LOCK_TIMEOUT),
         .PULSE_LEN    (PULSE_LEN),
         .MAX_RETRY    (MAX_RETRY),
         .RETRY_W      (RETRY_W)
      ) u_mon (
         .gt_txusrclk (gt_txusrclk),
         .gt_tx_reset (gt_tx_reset),
         .lock_in     (rx_block_lock[n]),
         .run         (run),
         .abort       (leave),
         .clr_retry   (clr_retry),
         .lock_sync   (lock_status[n]),
         .dp_req      (rx_dp_reset_req[n]),
         .fault_req   (fault_vec[n]),
         .retry       (retry_count[n*RETRY_W +: RETRY_W])
      );
   end

   assign userclk_tx_active = active_q;
   assign tx_rst            = tx_rst_q;
   assign reset_all_req     = rall_q;
   assign state             = state_q;

endmodule

// File: tb/tb_gt_reset_seq.sv
// Scoreboard bench for gt_reset_seq: directed lock/done stimulus,
// expected output change events queued ahead and matched by a monitor.
`timescale 1ns/1ps
module tb_gt_reset_seq;

   localparam int CH = 2;
   localparam int RW = 2;
   localparam int K_STATE = 0;
   localparam int K_TXRST = 1;
   localparam int K_ACT   = 2;
   localparam int K_LOCK  = 3;
   localparam int K_DP    = 4;
   localparam int K_RALL  = 5;
   localparam int K_RETRY = 6;

   typedef struct {
      int c;
      int k;
      int v;
   } ev_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             done = 1'b0;
   logic [CH-1:0]    lock_in = '1;
   logic             active, tx_rst, rall;
   logic [CH-1:0]    dp_req, lock_st;
   logic [1:0]       st;
   logic [CH*RW-1:0] retry;

   ev_t exp_q[$];
   int  cyc = 0;
   int  t0 = 0;
   int  n_chk = 0;
   int  n_fail = 0;
   bit  mon_en = 1'b0;

   logic [1:0]       p_st;
   logic             p_tx, p_act, p_rall;
   logic [CH-1:0]    p_lock, p_dp;
   logic [CH*RW-1:0] p_retry;

   gt_reset_seq #(
      .CH_COUNT     (2),
      .SYNC_STAGES  (2),
      .RST_STAGES   (4),
      .LOCK_TIMEOUT (100),
      .PULSE_LEN    (4),
      .MAX_RETRY    (2)
   ) dut (
      .gt_txusrclk       (clk),
      .gt_tx_reset       (rst),
      .gt_reset_tx_done  (done),
      .rx_block_lock     (lock_in),
      .userclk_tx_active (active),
      .tx_rst            (tx_rst),
      .rx_dp_reset_req   (dp_req),
      .reset_all_req     (rall),
      .state             (st),
      .lock_status       (lock_st),
      .retry_count       (retry)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic string kname(input int k);
      case (k)
         K_STATE: return "state";
         K_TXRST: return "tx_rst";
         K_ACT:   return "userclk_tx_active";
         K_LOCK:  return "lock_status";
         K_DP:    return "rx_dp_reset_req";
         K_RALL:  return "reset_all_req";
         default: return "retry_count";
      endcase
   endfunction

   task automatic expect_ev(input int c, input int k, input int v);
      ev_t e;
      e.c = c;
      e.k = k;
      e.v = v;
      exp_q.push_back(e);
   endtask

   task automatic got_ev(input int k, input int v);
      ev_t e;
      int  rel;
      rel = cyc - t0;
      n_chk++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL unexpected %s: got %0h at cycle %0d, required no change",
                  kname(k), v, rel);
      end else begin
         e = exp_q.pop_front();
         if (e.c != rel || e.k != k || e.v != v) begin
            n_fail++;
            $display("FAIL %s@%0d: got %s=%0h at cycle %0d, required %s=%0h at cycle %0d",
                     kname(e.k), e.c, kname(k), v, rel, kname(e.k), e.v, e.c);
         end
      end
   endtask

   task automatic chk(input string nm, input int got, input int want);
      n_chk++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", nm, got, want);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_active"}, int'(active), 0);
      chk({tag, "_tx_rst"}, int'(tx_rst), 1);
      chk({tag, "_dp_req"}, int'(dp_req), 0);
      chk({tag, "_reset_all"}, int'(rall), 0);
      chk({tag, "_state"}, int'(st), 0);
      chk({tag, "_retry"}, int'(retry), 0);
      chk({tag, "_lock_status"}, int'(lock_st), 0);
   endtask

   task automatic wait_rel(input int n);
      while (cyc - t0 < n) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (st != p_st)         got_ev(K_STATE, int'(st));
         if (tx_rst != p_tx)     got_ev(K_TXRST, int'(tx_rst));
         if (active != p_act)    got_ev(K_ACT, int'(active));
         if (lock_st != p_lock)  got_ev(K_LOCK, int'(lock_st));
         if (dp_req != p_dp)     got_ev(K_DP, int'(dp_req));
         if (rall != p_rall)     got_ev(K_RALL, int'(rall));
         if (retry != p_retry)   got_ev(K_RETRY, int'(retry));
      end
      p_st    <= st;
      p_tx    <= tx_rst;
      p_act   <= active;
      p_lock  <= lock_st;
      p_dp    <= dp_req;
      p_rall  <= rall;
      p_retry <= retry;
   end

   initial begin
      repeat (3) @(negedge clk);
      #1;
      chk_reset("por");
      @(negedge clk);
      t0 = cyc;
      rst = 1'b0;
      mon_en = 1'b1;
      expect_ev(1, K_ACT, 1);
      expect_ev(2, K_STATE, 1);
      expect_ev(2, K_LOCK, 3);
      expect_ev(13, K_STATE, 2);
      expect_ev(17, K_TXRST, 0);
      wait_rel(10);
      done = 1'b1;

      // single ch0 timeout, ch1 untouched
      wait_rel(30);
      expect_ev(32, K_LOCK, 2);
      expect_ev(132, K_DP, 1);
      expect_ev(132, K_RETRY, 1);
      expect_ev(136, K_DP, 0);
      lock_in[0] = 1'b0;

      wait_rel(150);
      expect_ev(152, K_LOCK, 3);
      expect_ev(252, K_RETRY, 0);
      lock_in[0] = 1'b1;

      // ch1 lost for good: two retries then escalation
      wait_rel(270);
      expect_ev(272, K_LOCK, 1);
      expect_ev(372, K_DP, 2);
      expect_ev(372, K_RETRY, 4);
      expect_ev(376, K_DP, 0);
      expect_ev(476, K_DP, 2);
      expect_ev(476, K_RETRY, 8);
      expect_ev(480, K_DP, 0);
      expect_ev(580, K_STATE, 3);
      expect_ev(580, K_TXRST, 1);
      expect_ev(580, K_RALL, 1);
      expect_ev(584, K_STATE, 1);
      expect_ev(584, K_RALL, 0);
      expect_ev(584, K_RETRY, 0);
      expect_ev(585, K_STATE, 2);
      expect_ev(589, K_TXRST, 0);
      lock_in[1] = 1'b0;

      wait_rel(684);
      expect_ev(685, K_DP, 2);
      expect_ev(685, K_RETRY, 4);
      expect_ev(687, K_STATE, 1);
      expect_ev(687, K_TXRST, 1);
      expect_ev(687, K_DP, 0);
      done = 1'b0;

      wait_rel(700);
      expect_ev(703, K_STATE, 2);
      expect_ev(707, K_TXRST, 0);
      expect_ev(803, K_DP, 2);
      expect_ev(803, K_RETRY, 8);
      expect_ev(807, K_DP, 0);
      expect_ev(907, K_STATE, 3);
      expect_ev(907, K_TXRST, 1);
      expect_ev(907, K_RALL, 1);
      done = 1'b1;

      // reset lands mid-FAULT, checked before any clock edge
      wait_rel(908);
      #2;
      mon_en = 1'b0;
      chk("pre_reset_all", int'(rall), 1);
      rst = 1'b1;
      #1;
      chk_reset("mid_fault");

      repeat (3) @(negedge clk);
      while (exp_q.size() != 0) begin
         ev_t e;
         e = exp_q.pop_front();
         n_chk++;
         n_fail++;
         $display("FAIL %s@%0d: got no change, required %s=%0h at cycle %0d",
                  kname(e.k), e.c, kname(e.k), e.v, e.c);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/gt_reset_seq.md
GT_RESET_SEQ -- requirements
Module: gt_reset_seq

Interface
REQ-001 SHALL have parameter CH_COUNT, default 2: number of GT channels monitored.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth for asynchronous inputs, minimum 2.
REQ-003 SHALL have parameter RST_STAGES, default 4: tx_rst release delay in cycles, minimum 1.
REQ-004 SHALL have parameter LOCK_TIMEOUT, default 322266: cycles of lock loss (about 1 ms at 322 MHz) before recovery action.
REQ-005 SHALL have parameter PULSE_LEN, default 16: width in cycles of every reset request pulse.
REQ-006 SHALL have parameter MAX_RETRY, default 3: number of per-channel datapath resets allowed before a full reset; RETRY_W = clog2(MAX_RETRY+1).
REQ-007 SHALL have port gt_txusrclk, input, 1: clock.
REQ-008 SHALL have port gt_tx_reset, input, 1: reset, asynchronous, active-high.
REQ-009 SHALL have port gt_reset_tx_done, input, 1: GT TX reset done, asynchronous.
REQ-010 SHALL have port rx_block_lock, input, CH_COUNT: per-channel PCS block lock, asynchronous.
REQ-011 SHALL have port userclk_tx_active, output, 1: user clock active, to the GT wizard.
REQ-012 SHALL have port tx_rst, output, 1: synchronous TX datapath reset.
REQ-013 SHALL have port rx_dp_reset_req, output, CH_COUNT: per-channel RX datapath reset pulse.
REQ-014 SHALL have port reset_all_req, output, 1: full GT reset request pulse.
REQ-015 SHALL have port state, output, 2: current sequencer state.
REQ-016 SHALL have port lock_status, output, CH_COUNT: synchronised rx_block_lock.
REQ-017 SHALL have port retry_count, output, CH_COUNT*RETRY_W: per-channel retry counters, channel n in slice n.

Function
REQ-018 userclk_tx_active SHALL rise on the first gt_txusrclk edge after gt_tx_reset deasserts and SHALL stay high until reset.
REQ-019 gt_reset_tx_done and rx_block_lock SHALL pass through SYNC_STAGES flip-flops; all logic SHALL use only the synchronised copies.
REQ-020 The state machine SHALL have states INACTIVE=0, WAIT_DONE=1, RUN=2 and FAULT=3.
REQ-021 INACTIVE SHALL move to WAIT_DONE on the cycle after userclk_tx_active is high.
REQ-022 WAIT_DONE SHALL move to RUN when synchronised done is high.
REQ-023 RUN SHALL move to WAIT_DONE when synchronised done is low; this transition SHALL take priority over FAULT.
REQ-024 FAULT SHALL hold reset_all_req high for exactly PULSE_LEN cycles, then move to WAIT_DONE.
REQ-025 tx_rst SHALL deassert exactly RST_STAGES cycles after entry to RUN and SHALL reassert on the cycle after RUN is left.
REQ-026 Each channel SHALL own a counter that clears on every change of synchronised lock and that counts only in RUN while no pulse is active for that channel.
REQ-027 When the counter reaches LOCK_TIMEOUT-1 with lock low and retry < MAX_RETRY, the channel SHALL:
 - pulse rx_dp_reset_req[n] for PULSE_LEN cycles;
 - increment retry;
 - clear its counter.
REQ-028 The same timeout with retry == MAX_RETRY SHALL move the state machine to FAULT.
REQ-029 When the counter reaches LOCK_TIMEOUT-1 with lock high, retry SHALL clear to 0.
REQ-030 Channels SHALL time out independently, so simultaneous pulses are legal.
REQ-031 If any channel requests FAULT, FAULT SHALL win, and every active rx_dp_reset_req pulse SHALL abort on the next cycle.
REQ-032 Leaving RUN SHALL abort all pulses and clear all timeout counters.
REQ-033 Exiting FAULT SHALL clear all retry counters.
REQ-034 The retry counter SHALL never exceed MAX_RETRY.

Reset
REQ-035 While gt_tx_reset is high, the outputs SHALL immediately take these values:
 - userclk_tx_active = 0, tx_rst = 1, rx_dp_reset_req = 0, reset_all_req = 0;
 - state = INACTIVE;
 - retry_count = 0, lock_status = 0.
REQ-036 Synchroniser flops, timeout counters and pulse counters SHALL also reset asynchronously to 0.
REQ-037 Reset asserted mid-pulse SHALL terminate the pulse with no residual cycle.

Structure
REQ-038 A shared package SHALL hold the state encodings and the default constants: LOCK_TIMEOUT, PULSE_LEN, MAX_RETRY.
REQ-039 The per-channel logic (synchroniser, timeout counter, pulse generator, retry counter) SHALL be a sub-module, gt_reset_seq_lock_mon, instantiated CH_COUNT times in a generate loop.

Verification
All scenarios use CH_COUNT=2, SYNC_STAGES=2, RST_STAGES=4, LOCK_TIMEOUT=100, PULSE_LEN=4, MAX_RETRY=2.
REQ-040 Release reset at cycle 0 with done high from cycle 10 -> active=1 at cycle 1, WAIT_DONE at cycle 2, RUN at cycle 13, tx_rst=0 at cycle 17.
REQ-041 In RUN, drop ch0 lock -> rx_dp_reset_req[0] high for 4 cycles starting 100 cycles after the synchronised drop, retry0=1, and ch1 unaffected.
REQ-042 Hold ch1 lock low permanently -> two 4-cycle pulses spaced 104 cycles apart, then FAULT, reset_all_req high for 4 cycles, retries cleared to 0, state WAIT_DONE.
REQ-043 Restore lock after one retry and hold it for 100 cycles -> retry0 returns to 0.
REQ-044 Drop done mid-pulse -> state WAIT_DONE, tx_rst=1 on the next cycle, pulse aborted.
REQ-045 Assert gt_tx_reset mid-FAULT -> all outputs take their REQ-035 values with no clock edge required.
